// File: rtl/tx_stream_pkg.sv
// Shared state encoding, gain constants and the 16-bit saturation helper
// used by the transmit stream core.
package tx_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    STREAM  = 2'd2,
    DRAIN   = 2'd3
  } tx_state_t;

  localparam int GAIN_FRAC_BITS = 7;
  localparam int GAIN_ROUND     = 64;

  localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

  function automatic logic signed [15:0] sat16(input logic signed [24:0] v);
    logic signed [15:0] res;
    if (v > 25'(SAMPLE_MAX)) begin
      res = SAMPLE_MAX;
    end else if (v < 25'(SAMPLE_MIN)) begin
      res = SAMPLE_MIN;
    end else begin
      res = v[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/tx_stream_core_fifo.sv
// Synchronous FIFO with registered read data and occupancy counter;
// depth must be a power of two so the pointers wrap naturally.
module tx_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             push_s;
  logic             pop_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign push_s    = wr_en_i && !full_o;
  assign pop_s     = rd_en_i && !empty_o;
  assign level_o   = count_q;
  assign rd_data_o = rd_data_q;

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tx_stream_core.sv
// Transmit stream core: FIFO buffering, prefill/stream/drain control and a
// 3-stage gain pipeline. Optional macro TX_UNDERFLOW_COUNT_EN adds underflow_count.
module tx_stream_core
  import tx_stream_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int PREFILL_LEVEL  = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [16*NUMBER_OF_LINE-1:0]     s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [7:0]                       gain,
  output logic [16*NUMBER_OF_LINE-1:0]     dac_data,
  output logic                             dac_valid,
  output logic                             underflow,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic [1:0]                       tx_state
`ifdef TX_UNDERFLOW_COUNT_EN
  ,output logic [15:0]                     underflow_count
`endif
);

  localparam int W  = 16*NUMBER_OF_LINE;
  localparam int LW = $clog2(FIFO_DEPTH)+1;
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL_LEVEL);

  tx_state_t        state_q, state_d;
  logic             underflow_q, underflow_d;
  logic             pop_s;
  logic             full_s, empty_s;
  logic [LW-1:0]    level_s;
  logic [W-1:0]     rd_data_s;

  logic             v1_q, v2_q, dac_valid_q;
  logic [7:0]       gain1_q;
  logic signed [24:0] prod_d [NUMBER_OF_LINE];
  logic signed [24:0] prod_q [NUMBER_OF_LINE];
  logic signed [24:0] round_s [NUMBER_OF_LINE];
  logic [W-1:0]     dac_data_d, dac_data_q;

  tx_sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .wr_en_i   (s_valid),
    .wr_data_i (s_data),
    .rd_en_i   (pop_s),
    .rd_data_o (rd_data_s),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .level_o   (level_s)
  );

  assign s_ready    = !full_s;
  assign fifo_level = level_s;
  assign tx_state   = state_q;
  assign underflow  = underflow_q;
  assign dac_data   = dac_data_q;
  assign dac_valid  = dac_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      underflow_q <= underflow_d;
    end
  end

  // Disable wins over underflow in STREAM: the flag is for starvation while enabled.
  always_comb begin
    state_d     = state_q;
    underflow_d = underflow_q;
    pop_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = PREFILL;
          underflow_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      PREFILL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (level_s >= PREFILL_L) begin
          state_d = STREAM;
        end else begin
          state_d = PREFILL;
        end
      end
      STREAM: begin
        pop_s = !empty_s;
        if (!enable) begin
          state_d = DRAIN;
        end else if (empty_s) begin
          state_d     = PREFILL;
          underflow_d = 1'b1;
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        pop_s = !empty_s;
        if (empty_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod_d     = '{default: '0};
    round_s    = '{default: '0};
    dac_data_d = '0;
    for (int i = 0; i < NUMBER_OF_LINE; i++) begin
      prod_d[i]  = 25'($signed(rd_data_s[16*i +: 16])) * 25'($signed({1'b0, gain1_q}));
      round_s[i] = (prod_q[i] + 25'(GAIN_ROUND)) >>> GAIN_FRAC_BITS;
      dac_data_d[16*i +: 16] = v2_q ? sat16(round_s[i]) : 16'd0;
    end
  end

  // Gain travels alongside the popped word so a mid-stream change hits word boundaries.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q        <= 1'b0;
      gain1_q     <= 8'd0;
      v2_q        <= 1'b0;
      prod_q      <= '{default: '0};
      dac_valid_q <= 1'b0;
      dac_data_q  <= '0;
    end else begin
      v1_q        <= pop_s;
      gain1_q     <= gain;
      v2_q        <= v1_q;
      prod_q      <= prod_d;
      dac_valid_q <= v2_q;
      dac_data_q  <= dac_data_d;
    end
  end

`ifdef TX_UNDERFLOW_COUNT_EN
  logic [15:0] uf_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      uf_count_q <= 16'd0;
    end else if ((state_q == STREAM) && enable && empty_s && (uf_count_q != 16'hFFFF)) begin
      uf_count_q <= uf_count_q + 16'd1;
    end else begin
      uf_count_q <= uf_count_q;
    end
  end

  assign underflow_count = uf_count_q;
`endif

endmodule

// File: tb/tb_tx_stream_core.sv
// Scoreboard bench for tx_stream_core: expected words are queued on push
// and compared as dac_valid words emerge.
module tb_tx_stream_core;

  localparam int NL = 8;
  localparam int W  = 16*NL;
  localparam int FD = 16;
  localparam int PL = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    gain = 8'h80;
  logic [W-1:0]  dac_data;
  logic          dac_valid;
  logic          underflow;
  logic [4:0]    fifo_level;
  logic [1:0]    tx_state;
`ifdef TX_UNDERFLOW_COUNT_EN
  logic [15:0]   underflow_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int n_out    = 0;
  logic [W-1:0] exp_q [$];

  tx_stream_core #(.NUMBER_OF_LINE(NL), .FIFO_DEPTH(FD), .PREFILL_LEVEL(PL)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .gain       (gain),
    .dac_data   (dac_data),
    .dac_valid  (dac_valid),
    .underflow  (underflow),
    .fifo_level (fifo_level),
    .tx_state   (tx_state)
`ifdef TX_UNDERFLOW_COUNT_EN
    , .underflow_count(underflow_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_word(input logic [W-1:0] d, input logic [7:0] g);
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < NL; i++) begin
      int s;
      int p;
      int r;
      s = $signed(d[16*i +: 16]);
      p = s * int'(g);
      r = (p + 64) >>> 7;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      o[16*i +: 16] = r[15:0];
    end
    return o;
  endfunction

  task automatic push_word(input logic [W-1:0] d, input logic [W-1:0] e);
    int g;
    g = 0;
    @(negedge clock);
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (s_ready) begin
      @(posedge clock);
      exp_q.push_back(e);
    end else begin
      check_eq("push_timeout", W'(s_ready), W'(1));
    end
  endtask

  task automatic wait_sb_empty(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 80) begin
      @(negedge clock);
      g++;
    end
    check_eq(tag, W'(exp_q.size()), W'(0));
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st);
    int g;
    g = 0;
    while (tx_state != st && g < 60) begin
      @(negedge clock);
      g++;
    end
    check_eq(tag, W'(tx_state), W'(st));
  endtask

  // Output monitor: every valid word must match the scoreboard head, idle cycles must be zero.
  always @(negedge clock) begin
    if (dac_valid) begin
      n_out++;
      if (exp_q.size() == 0) check_eq("sb_unexpected_valid", W'(dac_valid), W'(0));
      else check_eq("sb_data", dac_data, exp_q.pop_front());
    end else begin
      check_eq("idle_zero", dac_data, '0);
    end
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] gword;
    logic [W-1:0] gexp [3];
    logic [7:0]   gval [3];
    int acc;
    int g;
    int n0;

    gword   = {16'h0100, 16'hC000, 16'h4000, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 16'h1000};
    gval[0] = 8'hC0;
    gval[1] = 8'hFF;
    gval[2] = 8'h40;
    gexp[0] = {16'h0180, 16'hA000, 16'h6000, 16'hFFFF, 16'h0002, 16'h8000, 16'h7FFF, 16'h1800};
    gexp[1] = {16'h01FE, 16'h8080, 16'h7F80, 16'hFFFE, 16'h0002, 16'h8000, 16'h7FFF, 16'h1FE0};
    gexp[2] = {16'h0080, 16'hE000, 16'h2000, 16'h0000, 16'h0001, 16'hC000, 16'h4000, 16'h0800};

    repeat (3) @(negedge clock);
    check_eq("rst_dac_valid", W'(dac_valid), W'(0));
    check_eq("rst_dac_data", dac_data, W'(0));
    check_eq("rst_underflow", W'(underflow), W'(0));
    check_eq("rst_level", W'(fifo_level), W'(0));
    check_eq("rst_state", W'(tx_state), W'(0));
    check_eq("rst_ready", W'(s_ready), W'(1));
    reset  = 1'b0;
    enable = 1'b1;

    // Basic stream followed by underflow once the source stalls.
    for (int k = 0; k < 8; k++) push_word({8{16'h4000}}, {8{16'h4000}});
    @(negedge clock);
    s_valid = 1'b0;
    check_eq("basic_level", W'(fifo_level), W'(8));
    check_eq("basic_prefill", W'(tx_state), W'(1));
    @(negedge clock);
    check_eq("basic_stream", W'(tx_state), W'(2));
    check_eq("lat_pop_cycle", W'(dac_valid), W'(0));
    repeat (2) begin
      @(negedge clock);
      check_eq("lat_wait", W'(dac_valid), W'(0));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("basic_run", W'(dac_valid), W'(i < 8));
    end
    check_eq("uf_flag", W'(underflow), W'(1));
    check_eq("uf_state", W'(tx_state), W'(1));
`ifdef TX_UNDERFLOW_COUNT_EN
    check_eq("uf_count", W'(underflow_count), W'(1));
`endif

    // Gain arithmetic: rounding and saturation at three gain settings.
    for (int ph = 0; ph < 3; ph++) begin
      gain = gval[ph];
      for (int k = 0; k < 8; k++) push_word(gword, gexp[ph]);
      @(negedge clock);
      s_valid = 1'b0;
      wait_sb_empty("gain_out");
      repeat (3) @(negedge clock);
    end
    check_eq("gain_uf_state", W'(tx_state), W'(1));

    // Reset with the pipe full and the sticky flag set.
    gain = 8'h80;
    for (int k = 0; k < 12; k++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      push_word(w, model_word(w, gain));
    end
    @(negedge clock);
    s_valid = 1'b0;
    g = 0;
    while (!dac_valid && g < 20) begin
      @(negedge clock);
      g++;
    end
    check_eq("mid_valid", W'(dac_valid), W'(1));
    check_eq("mid_state", W'(tx_state), W'(2));
    check_eq("mid_uf", W'(underflow), W'(1));
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    check_eq("mrst_valid", W'(dac_valid), W'(0));
    check_eq("mrst_data", dac_data, W'(0));
    check_eq("mrst_level", W'(fifo_level), W'(0));
    check_eq("mrst_state", W'(tx_state), W'(0));
    check_eq("mrst_uf", W'(underflow), W'(0));
`ifdef TX_UNDERFLOW_COUNT_EN
    check_eq("mrst_count", W'(underflow_count), W'(0));
`endif
    exp_q.delete();
    reset = 1'b0;

    // Fill to full while disabled, then stream everything out in order.
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      s_data  = w;
      s_valid = 1'b1;
      if (s_ready) begin
        exp_q.push_back(model_word(w, gain));
        acc++;
      end
    end
    @(negedge clock);
    s_valid = 1'b0;
    check_eq("full_accepted", W'(acc), W'(16));
    check_eq("full_ready", W'(s_ready), W'(0));
    check_eq("full_level", W'(fifo_level), W'(16));
    check_eq("full_idle", W'(tx_state), W'(0));
    enable = 1'b1;
    @(negedge clock);
    check_eq("full_prefill", W'(tx_state), W'(1));
    wait_sb_empty("full_out");
    repeat (3) @(negedge clock);

    // Drain: disable while streaming with 10 words buffered.
    enable = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("drain_idle0", W'(tx_state), W'(0));
    for (int k = 0; k < 10; k++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      push_word(w, model_word(w, gain));
    end
    @(negedge clock);
    s_valid = 1'b0;
    n0 = n_out;
    enable = 1'b1;
    wait_state("drain_to_stream", 2'd2);
    check_eq("drain_level", W'(fifo_level), W'(10));
    enable = 1'b0;
    @(negedge clock);
    check_eq("drain_state", W'(tx_state), W'(3));
    wait_state("drain_to_idle", 2'd0);
    wait_sb_empty("drain_out");
    repeat (2) @(negedge clock);
    check_eq("drain_count", W'(n_out - n0), W'(10));
    check_eq("drain_uf", W'(underflow), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tx_stream_core.md
Name: tx_stream_core

Overview:
- Transmit-side counterpart of the receive DSP path.
- Accepts parallel sample words (NUMBER_OF_LINE real 16-bit lanes per beat) over a valid/ready stream and buffers them in a sync FIFO.
- Applies per-word digital gain with rounding and saturation.
- Emits one DAC word per clock while streaming, handling prefill, drain and underflow via a state machine. Sits between the baseband/DUC source and the DAC data ports.

Parameters:
- NUMBER_OF_LINE, 8, samples per word (lane i occupies bits 16*(i+1)-1:16*i).
- FIFO_DEPTH, 16, FIFO words; power of 2, at least 4.
- PREFILL_LEVEL, 8, words required before streaming starts; 1..FIFO_DEPTH.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- enable  in  1  transmit enable (level)
- s_data  in  16*NUMBER_OF_LINE  input word, signed lanes
- s_valid  in  1  input word valid
- s_ready  out  1  FIFO can accept a word
- gain  in  8  unsigned Q1.7 (0x80 = 1.0), sampled at each pop
- dac_data  out  16*NUMBER_OF_LINE  scaled output word
- dac_valid  out  1  dac_data carries a popped word
- underflow  out  1  sticky underflow flag
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- tx_state  out  2  state encoding (IDLE=0, PREFILL=1, STREAM=2, DRAIN=3)

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, pointers 0. Reset mid-stream discards FIFO contents and in-flight pipeline data; outputs are 0 on the cycle after reset is high.
- Push: s_valid && s_ready. s_ready = !full, independent of state; pushes are allowed in IDLE.
- Full: s_ready low; no push. Simultaneous push and pop on a full FIFO cannot occur because s_ready is low when full.
- Simultaneous push and pop otherwise: fifo_level unchanged.
- fifo_level is registered and reflects all pushes/pops of the previous cycle.
- State machine:
  - IDLE: no pops. enable=1 moves to PREFILL and clears underflow on that transition.
  - PREFILL: no pops. fifo_level >= PREFILL_LEVEL moves to STREAM. enable=0 returns to IDLE with FIFO contents retained.
  - STREAM: pops one word every cycle the FIFO is non-empty.
    - Empty cycle (no pop): set underflow, move to PREFILL.
    - enable=0: move to DRAIN. The pop in that cycle still occurs if the FIFO is non-empty.
  - DRAIN: pops every cycle until empty, then IDLE. enable has no effect in DRAIN. Empty in DRAIN is not an underflow.
- Pipeline:
  - Pop at cycle N; FIFO read data registered at N+1.
  - Per-lane product registered at N+2.
  - Round/saturate result on dac_data at N+3, with dac_valid=1 at N+3. Latency is 3 cycles, fully pipelined, one word per clock.
  - The gain value used is the one present at cycle N, carried along the pipe.
- Arithmetic, per lane:
  - p = signed(sample) * signed({1'b0, gain}), 25-bit.
  - r = (p + 64) >>> 7 (arithmetic shift, round half up).
  - Saturate r to [-32768, 32767].
- dac_data is 0 whenever dac_valid=0. Non-valid cycles output zeros, not held values.
- underflow stays set until the next IDLE->PREFILL transition or reset.

Optional Feature:
- Macro: TX_UNDERFLOW_COUNT_EN.
- Defined: adds output underflow_count (16 bits), which increments on each underflow event and saturates at 0xFFFF. It clears only on reset, not on re-enable.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tx_stream_pkg holds:
  - tx_state_t enum (IDLE, PREFILL, STREAM, DRAIN) with 2-bit encoding.
  - GAIN_FRAC_BITS=7, GAIN_ROUND=64.
  - SAMPLE_MAX/SAMPLE_MIN constants.
  - Function sat16() (25-bit signed in, 16-bit signed out).
- Sub-module tx_sync_fifo: parameterised width/depth, registered read data, full/empty/level outputs, synchronous active-high reset.

Test Plan:
- Basic stream:
  - Stimulus: push 8 words, lane value 0x4000, gain 0x80, enable=1.
  - Response: STREAM reached after level hits 8; 8 consecutive dac_valid cycles with every lane 0x4000; first output 3 cycles after first pop.
- Gain math:
  - Stimulus: lanes {0x1000, 0x7FFF, 0x8000, 0x0001, 0xFFFF}, gain 0xC0 then 0xFF then 0x40.
  - Response at 0xC0: 0x1000 gives 0x1800.
  - Response at 0xFF: 0x7FFF gives 0x7FFF (sat); 0x8000 gives 0x8000 (sat).
  - Response at 0x40: 0x0001 gives 0x0001; 0xFFFF gives 0x0000.
- Underflow:
  - Stimulus: PREFILL_LEVEL=8; push 8 words, then stall s_valid.
  - Response: 8 valid outputs; underflow=1; tx_state returns to PREFILL; dac_data=0 on non-valid cycles; count=1 if TX_UNDERFLOW_COUNT_EN.
- Full / backpressure:
  - Stimulus: enable=0, push 20 words continuously.
  - Response: s_ready drops after 16 accepted; fifo_level=16; no words lost when enable later asserted, all 16 output in order.
- Drain:
  - Stimulus: in STREAM with 10 words buffered, deassert enable.
  - Response: DRAIN; all buffered words output; IDLE on empty; underflow remains 0.
- Reset mid-operation:
  - Stimulus: assert reset during STREAM with a full pipe.
  - Response: next cycle dac_valid=0, dac_data=0, fifo_level=0, tx_state=IDLE, underflow=0.
